sdram_aref: RTL

SDRAM auto-refresh controller that sits directly downstream of SDRAM power-up initialisation. After initialisation completes it times the 15 us refresh interval, raises a refresh request to the SDRAM command arbiter, and, once granted, drives a PRECHARGE-ALL / AUTO-REFRESH command sequence with tRP/tRC spacing, then signals completion. Commands use the same 4-bit {cs_n, ras_n, cas_n, we_n} encoding as the init stage.

---
 rtl/sdram_aref_if.sv | 31 +++
 rtl/sdram_aref.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/sdram_aref_if.sv
// Bundle of the refresh controller's handshake and command signals.
// master: the refresh controller. slave: the arbiter / init-stage side.
interface sdram_aref_if;
  logic        init_done;
  logic        ref_en;
  logic        ref_req;
  logic [3:0]  aref_cmd;
  logic [11:0] aref_addr;
  logic        flag_ref_end;
  logic        ref_overrun;

  modport master (
    input  init_done,
    input  ref_en,
    output ref_req,
    output aref_cmd,
    output aref_addr,
    output flag_ref_end,
    output ref_overrun
  );

  modport slave (
    output init_done,
    output ref_en,
    input  ref_req,
    input  aref_cmd,
    input  aref_addr,
    input  flag_ref_end,
    input  ref_overrun
  );
endinterface

// File: rtl/sdram_aref.sv
// SDRAM auto-refresh controller. Times the refresh interval once init is done,
// requests the command bus, and on grant issues PRECHARGE-ALL then AUTO-REFRESH
// with tRP/tRC NOP spacing, pulsing flag_ref_end in the final cycle.
module sdram_aref #(
  parameter int unsigned FREQUENCY     = 50,
  parameter int unsigned REF_PERIOD_US = 15,
  parameter int unsigned TRP_CYC       = 2,
  parameter int unsigned TRC_CYC       = 4
) (
  input  logic         clk,
  input  logic         rst,
  sdram_aref_if.master bus
);

  localparam int unsigned RefCnt  = REF_PERIOD_US * FREQUENCY;
  localparam logic [15:0] RefLast = 16'(RefCnt - 1);
  localparam logic [3:0]  TrpLast = 4'(TRP_CYC - 1);
  localparam logic [3:0]  TrcLast = 4'(TRC_CYC - 1);

  localparam logic [3:0] CmdPre  = 4'b0010;
  localparam logic [3:0] CmdAref = 4'b0001;
  localparam logic [3:0] CmdNop  = 4'b0111;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StWaitRp,
    StAref,
    StWaitRc
  } state_e;

  logic [15:0] timer_q, timer_d;
  logic        tick;
  logic        start;
  logic        ref_req_q, ref_req_d;
  logic        overrun_q, overrun_d;
  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [3:0]  cmd_q, cmd_d;
  logic        flag_q, flag_d;

  // Refresh interval timer; held at zero until the SDRAM is initialised.
  always_comb begin
    tick    = bus.init_done && (timer_q == RefLast);
    timer_d = timer_q + 16'd1;
    if (!bus.init_done || tick) begin
      timer_d = 16'd0;
    end
  end

  // Request and overrun bookkeeping; a tick coinciding with a start re-arms the request.
  always_comb begin
    start     = (state_q == StIdle) && ref_req_q && bus.ref_en;
    ref_req_d = ref_req_q;
    if (!bus.init_done) begin
      ref_req_d = 1'b0;
    end else if (tick) begin
      ref_req_d = 1'b1;
    end else if (start) begin
      ref_req_d = 1'b0;
    end
    overrun_d = overrun_q | (tick & ref_req_q & ~start);
  end

  // Sequence next-state; once started it runs to completion regardless of inputs.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StPre;
        end
      end
      StPre: begin
        state_d    = StWaitRp;
        wait_cnt_d = 4'd0;
      end
      StWaitRp: begin
        if (wait_cnt_q == TrpLast) begin
          state_d = StAref;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      StAref: begin
        state_d    = StWaitRc;
        wait_cnt_d = 4'd0;
      end
      StWaitRc: begin
        if (wait_cnt_q == TrcLast) begin
          state_d = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d    = StIdle;
        wait_cnt_d = 4'd0;
      end
    endcase
  end

  // Outputs decoded from next state so they line up with the state they describe.
  always_comb begin
    unique case (state_d)
      StPre:   cmd_d = CmdPre;
      StAref:  cmd_d = CmdAref;
      default: cmd_d = CmdNop;
    endcase
    flag_d = (state_d == StWaitRc) && (wait_cnt_d == TrcLast);
  end

  // Timer, request and sticky overrun state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q   <= 16'd0;
      ref_req_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      ref_req_q <= ref_req_d;
      overrun_q <= overrun_d;
    end
  end

  // Sequencer state with its registered command and completion flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      wait_cnt_q <= 4'd0;
      cmd_q      <= CmdNop;
      flag_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      cmd_q      <= cmd_d;
      flag_q     <= flag_d;
    end
  end

  assign bus.ref_req      = ref_req_q;
  assign bus.aref_cmd     = cmd_q;
  assign bus.aref_addr    = 12'b0100_0000_0000;
  assign bus.flag_ref_end = flag_q;
  assign bus.ref_overrun  = overrun_q;

endmodule
